// File: rtl/in_module_pkg.sv
// Shared I/O definitions for the CPU input/output pair: FSM state codes and
// 7-segment sign digit codes used alongside the output module.
package in_module_pkg;

   // Input handshake FSM state encoding
   localparam logic [1:0] IDLE         = 2'd0;
   localparam logic [1:0] WAIT_PRESS   = 2'd1;
   localparam logic [1:0] WAIT_RELEASE = 2'd2;
   localparam logic [1:0] DONE         = 2'd3;

   // BCD-style codes for the sign digit on the 7-segment display
   localparam logic [3:0] SIGN_BLANK = 4'hF;
   localparam logic [3:0] SIGN_MINUS = 4'hA;

endpackage

// File: rtl/in_module_key_debouncer.sv
// Synchronises the raw active-low confirm key, filters bounce, and emits
// single-cycle press/release pulses on debounced level transitions.
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clock,
   input  logic reset,
   input  logic key_raw,
   output logic level,
   output logic press_evt,
   output logic release_evt
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          key_s1;
   logic          key_s2;
   logic [CW-1:0] cnt;

   // Two-flop synchroniser; idles at released (high)
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         key_s1 <= 1'b1;
         key_s2 <= 1'b1;
      end else begin
         key_s1 <= key_raw;
         key_s2 <= key_s1;
      end
   end

   // Accept a new level only after it differs for DEBOUNCE_CYCLES straight cycles
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         level       <= 1'b1;
         cnt         <= '0;
         press_evt   <= 1'b0;
         release_evt <= 1'b0;
      end else begin
         press_evt   <= 1'b0;
         release_evt <= 1'b0;
         if (key_s2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level       <= key_s2;
            cnt         <= '0;
            press_evt   <= ~key_s2;
            release_evt <= key_s2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/in_module.sv
// CPU IN-instruction front end: waits for an operator confirm press/release,
// captures the sign-magnitude switches as two's complement, and handshakes
// with the CPU via in_on / in_done.
module in_module
   import in_module_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SW_WIDTH        = 18,
   parameter int DATA_WIDTH      = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [SW_WIDTH-1:0]   SW,
   input  logic                  KEY,
   input  logic                  in_on,
   output logic [DATA_WIDTH-1:0] binaryS,
   output logic                  in_done,
   output logic                  in_wait
);

   logic [SW_WIDTH-1:0] sw_s1;
   logic [SW_WIDTH-1:0] sw_s2;
   logic [1:0]          state;
   logic                key_level;
   logic                press_evt;
   logic                release_evt;

   // Sign-magnitude to two's complement; negative zero collapses to zero
   function automatic logic signed [DATA_WIDTH-1:0] sm_to_twos(input logic [SW_WIDTH-1:0] sw);
      logic [DATA_WIDTH-1:0] mag;
      mag = '0;
      mag[SW_WIDTH-2:0] = sw[SW_WIDTH-2:0];
      return sw[SW_WIDTH-1] ? -mag : mag;
   endfunction

   key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key (
      .clock      (clock),
      .reset      (reset),
      .key_raw    (KEY),
      .level      (key_level),
      .press_evt  (press_evt),
      .release_evt(release_evt)
   );

   // Two-flop synchroniser for the switch bank
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sw_s1 <= '0;
         sw_s2 <= '0;
      end else begin
         sw_s1 <= SW;
         sw_s2 <= sw_s1;
      end
   end

   // Handshake FSM; dropping in_on anywhere returns to IDLE, capture only on a press edge
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         binaryS <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_on) state <= WAIT_PRESS;
            end
            WAIT_PRESS: begin
               if (!in_on) begin
                  state <= IDLE;
               end else if (press_evt) begin
                  binaryS <= sm_to_twos(sw_s2);
                  state   <= WAIT_RELEASE;
               end
            end
            WAIT_RELEASE: begin
               if (!in_on)           state <= IDLE;
               else if (release_evt) state <= DONE;
            end
            default: begin
               if (!in_on) state <= IDLE;
            end
         endcase
      end
   end

   assign in_done = (state == DONE);
   assign in_wait = (state == WAIT_PRESS) || (state == WAIT_RELEASE);

endmodule

// File: tb/tb_in_module.sv
module tb_in_module;

   localparam int DC  = 4;
   localparam int SWW = 18;
   localparam int DW  = 32;

   logic           clock = 1'b0;
   logic           reset;
   logic [SWW-1:0] SW;
   logic           KEY;
   logic           in_on;
   logic [DW-1:0]  binaryS;
   logic           in_done;
   logic           in_wait;

   int checks = 0;
   int errors = 0;
   int press_cnt = 0;

   always #5 clock = ~clock;

   in_module #(
      .DEBOUNCE_CYCLES(DC),
      .SW_WIDTH       (SWW),
      .DATA_WIDTH     (DW)
   ) dut (
      .clock  (clock),
      .reset  (reset),
      .SW     (SW),
      .KEY    (KEY),
      .in_on  (in_on),
      .binaryS(binaryS),
      .in_done(in_done),
      .in_wait(in_wait)
   );

   always @(posedge clock) if (dut.u_key.press_evt) press_cnt <= press_cnt + 1;

   task automatic cyc(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (in_done) begin
            ok = 1'b1;
            break;
         end
         cyc(1);
      end
   endtask

   task automatic do_transaction(input logic [SWW-1:0] sw, output bit ok);
      SW = sw;
      cyc(3);
      in_on = 1'b1;
      cyc(2);
      KEY = 1'b0;
      cyc(10);
      KEY = 1'b1;
      wait_done(ok);
   endtask

   task automatic test_reset;
      reset = 1'b0; KEY = 1'b1; in_on = 1'b0; SW = '0;
      cyc(3);
      checks++; if (binaryS !== 32'h0) begin errors++; $display("FAIL reset_binaryS got %h want %h", binaryS, 32'h0); end
      checks++; if (in_done !== 1'b0) begin errors++; $display("FAIL reset_in_done got %b want 0", in_done); end
      checks++; if (in_wait !== 1'b0) begin errors++; $display("FAIL reset_in_wait got %b want 0", in_wait); end
      reset = 1'b1;
      cyc(3);
   endtask

   task automatic test_basic;
      bit ok;
      do_transaction(18'h0007B, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout got 0 want 1"); end
      checks++; if (binaryS !== 32'h0000007B) begin errors++; $display("FAIL basic_value got %h want %h", binaryS, 32'h0000007B); end
      checks++; if (in_wait !== 1'b0) begin errors++; $display("FAIL basic_in_wait got %b want 0", in_wait); end
      cyc(5);
      checks++; if (in_done !== 1'b1) begin errors++; $display("FAIL basic_done_held got %b want 1", in_done); end
      in_on = 1'b0;
      cyc(1);
      checks++; if (in_done !== 1'b0) begin errors++; $display("FAIL basic_done_fall got %b want 0", in_done); end
      checks++; if (binaryS !== 32'h0000007B) begin errors++; $display("FAIL basic_hold_idle got %h want %h", binaryS, 32'h0000007B); end
      cyc(2);
   endtask

   task automatic test_conversion;
      logic [SWW-1:0] sw_v [4] = '{18'h2007B, 18'h20000, 18'h1FFFF, 18'h3FFFF};
      logic [DW-1:0]  exp_v[4] = '{32'hFFFFFF85, 32'h00000000, 32'h0001FFFF, 32'hFFFE0001};
      bit ok;
      for (int i = 0; i < 4; i++) begin
         do_transaction(sw_v[i], ok);
         checks++;
         if (!ok || binaryS !== exp_v[i]) begin
            errors++;
            $display("FAIL conv_%0d got %h done=%b want %h done=1", i, binaryS, ok, exp_v[i]);
         end
         in_on = 1'b0;
         cyc(2);
      end
   endtask

   task automatic test_bounce;
      bit ok;
      SW = 18'h00055;
      cyc(3);
      press_cnt = 0;
      in_on = 1'b1;
      cyc(2);
      for (int i = 0; i < 3; i++) begin
         KEY = 1'b0; cyc(3);
         KEY = 1'b1; cyc(3);
      end
      cyc(4);
      checks++; if (binaryS !== 32'hFFFE0001) begin errors++; $display("FAIL bounce_no_capture got %h want %h", binaryS, 32'hFFFE0001); end
      checks++; if (press_cnt !== 0) begin errors++; $display("FAIL bounce_glitch_press got %0d want 0", press_cnt); end
      KEY = 1'b0;
      cyc(10);
      checks++; if (binaryS !== 32'h00000055) begin errors++; $display("FAIL bounce_capture got %h want %h", binaryS, 32'h00000055); end
      checks++; if (in_wait !== 1'b1 || in_done !== 1'b0) begin errors++; $display("FAIL bounce_wait_release got wait=%b done=%b want wait=1 done=0", in_wait, in_done); end
      KEY = 1'b1;
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL bounce_done_timeout got 0 want 1"); end
      checks++; if (press_cnt !== 1) begin errors++; $display("FAIL bounce_press_count got %0d want 1", press_cnt); end
      in_on = 1'b0;
      cyc(2);
   endtask

   task automatic test_held;
      bit ok;
      KEY = 1'b0;
      cyc(10);
      SW = 18'h00ABC;
      cyc(3);
      in_on = 1'b1;
      cyc(10);
      checks++; if (in_wait !== 1'b1 || binaryS !== 32'h00000055) begin errors++; $display("FAIL held_no_capture got wait=%b val=%h want wait=1 val=%h", in_wait, binaryS, 32'h00000055); end
      KEY = 1'b1;
      cyc(10);
      checks++; if (in_wait !== 1'b1 || in_done !== 1'b0 || binaryS !== 32'h00000055) begin errors++; $display("FAIL held_after_release got wait=%b done=%b val=%h want 1 0 %h", in_wait, in_done, binaryS, 32'h00000055); end
      KEY = 1'b0;
      cyc(10);
      checks++; if (binaryS !== 32'h00000ABC) begin errors++; $display("FAIL held_repress got %h want %h", binaryS, 32'h00000ABC); end
      KEY = 1'b1;
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL held_done_timeout got 0 want 1"); end
      in_on = 1'b0;
      cyc(2);
   endtask

   task automatic test_abort;
      int done_seen = 0;
      SW = 18'h00111;
      cyc(3);
      in_on = 1'b1;
      cyc(3);
      checks++; if (in_wait !== 1'b1) begin errors++; $display("FAIL abort_enter got %b want 1", in_wait); end
      in_on = 1'b0;
      cyc(2);
      checks++; if (in_wait !== 1'b0) begin errors++; $display("FAIL abort_idle got %b want 0", in_wait); end
      KEY = 1'b0;
      for (int i = 0; i < 10; i++) begin cyc(1); if (in_done) done_seen++; end
      KEY = 1'b1;
      for (int i = 0; i < 10; i++) begin cyc(1); if (in_done) done_seen++; end
      checks++; if (done_seen !== 0) begin errors++; $display("FAIL abort_done_seen got %0d want 0", done_seen); end
      checks++; if (binaryS !== 32'h00000ABC) begin errors++; $display("FAIL abort_hold got %h want %h", binaryS, 32'h00000ABC); end
   endtask

   task automatic test_reset_mid;
      SW = 18'h00222;
      cyc(3);
      in_on = 1'b1;
      cyc(2);
      KEY = 1'b0;
      cyc(10);
      checks++; if (binaryS !== 32'h00000222 || in_wait !== 1'b1) begin errors++; $display("FAIL mid_pre got val=%h wait=%b want %h 1", binaryS, in_wait, 32'h00000222); end
      #2 reset = 1'b0;
      #1;
      checks++; if (binaryS !== 32'h0 || in_done !== 1'b0 || in_wait !== 1'b0) begin errors++; $display("FAIL mid_async got val=%h done=%b wait=%b want 0 0 0", binaryS, in_done, in_wait); end
      in_on = 1'b0;
      KEY = 1'b1;
      cyc(2);
      reset = 1'b1;
      cyc(10);
      checks++; if (binaryS !== 32'h0 || in_done !== 1'b0 || in_wait !== 1'b0) begin errors++; $display("FAIL mid_after got val=%h done=%b wait=%b want 0 0 0", binaryS, in_done, in_wait); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_conversion();
      test_bounce();
      test_held();
      test_abort();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
